// File: rtl/str_gbox.sv
// Valid/ready stream gearbox: splits wide words into LS-first slices or packs slices into wide words.
// Optional packet-end propagation and early upsize flush are enabled by defining STR_GBOX_LAST_EN.
module str_gbox #(
    parameter int DATA_UP_WIDTH = 24,
    parameter int DATA_DN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_UP_WIDTH-1:0] up_data,
    input  logic                     up_last,
    input  logic                     up_val,
    output logic                     up_rdy,
    output logic [DATA_DN_WIDTH-1:0] dn_data,
    output logic                     dn_last,
    output logic                     dn_val,
    input  logic                     dn_rdy
);
    localparam int UPW   = DATA_UP_WIDTH;
    localparam int DNW   = DATA_DN_WIDTH;
    localparam int NB    = (UPW > DNW) ? UPW / DNW : DNW / UPW;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    generate
        if ((UPW > DNW && (UPW % DNW) != 0) || (DNW > UPW && (DNW % UPW) != 0)) begin : g_bad_ratio
            $error("str_gbox: wider width must be an integer multiple of the narrower width");
        end
    endgenerate

    // run_q keeps up_rdy low while reset is held and releases it on the first clean edge
    logic run_q, run_d;
    logic up_last_eff;

`ifdef STR_GBOX_LAST_EN
    assign up_last_eff = up_last;
`else
    logic unused_up_last;
    assign unused_up_last = up_last;
    assign up_last_eff    = 1'b0;
`endif

    always_comb run_d = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= run_d;
    end

    generate
        if (UPW > DNW) begin : g_down
            logic [UPW-1:0]   hold_q, hold_d;
            logic             last_q, last_d;
            logic             held_q, held_d;
            logic [IDX_W-1:0] idx_q, idx_d;
            logic [DNW-1:0]   slice [2**IDX_W];
            logic             at_end, up_fire, dn_fire;

            // padded to a power of two so every idx value selects a defined entry
            for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_slice
                if (gi < NB) begin : g_used
                    assign slice[gi] = hold_q[gi*DNW +: DNW];
                end else begin : g_pad
                    assign slice[gi] = '0;
                end
            end

            assign at_end  = (idx_q == IDX_W'(NB - 1));
            assign up_rdy  = run_q & (~held_q | (dn_rdy & at_end));
            assign up_fire = up_val & up_rdy;
            assign dn_fire = held_q & dn_rdy;
            assign dn_val  = held_q;
            assign dn_data = slice[idx_q];
            assign dn_last = last_q & at_end;

            always_comb begin
                hold_d = hold_q;
                last_d = last_q;
                held_d = held_q;
                idx_d  = idx_q;
                if (up_fire) begin
                    hold_d = up_data;
                    last_d = up_last_eff;
                    held_d = 1'b1;
                    idx_d  = '0;
                end else if (dn_fire) begin
                    if (at_end) begin
                        held_d = 1'b0;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q <= '0;
                    last_q <= 1'b0;
                    held_q <= 1'b0;
                    idx_q  <= '0;
                end else begin
                    hold_q <= hold_d;
                    last_q <= last_d;
                    held_q <= held_d;
                    idx_q  <= idx_d;
                end
            end
        end else if (UPW < DNW) begin : g_up
            logic [DNW-1:0]   acc_q, acc_d, acc_w;
            logic [IDX_W-1:0] k_q, k_d;
            logic [DNW-1:0]   out_q, out_d;
            logic             out_last_q, out_last_d;
            logic             out_val_q, out_val_d;
            logic             up_fire, flush;

            for (genvar gi = 0; gi < NB; gi++) begin : g_acc
                assign acc_w[gi*UPW +: UPW] = (up_fire && k_q == IDX_W'(gi)) ?
                                              up_data : acc_q[gi*UPW +: UPW];
            end

            assign up_rdy  = run_q & ~(out_val_q & ~dn_rdy);
            assign up_fire = up_val & up_rdy;
            assign flush   = up_fire & ((k_q == IDX_W'(NB - 1)) | up_last_eff);
            assign dn_val  = out_val_q;
            assign dn_data = out_q;
            assign dn_last = out_last_q;

            always_comb begin
                acc_d      = acc_q;
                k_d        = k_q;
                out_d      = out_q;
                out_last_d = out_last_q;
                out_val_d  = out_val_q;
                if (out_val_q && dn_rdy) out_val_d = 1'b0;
                // a flush only happens when the output is free or draining this cycle
                if (flush) begin
                    out_d      = acc_w;
                    out_last_d = up_last_eff;
                    out_val_d  = 1'b1;
                    acc_d      = '0;
                    k_d        = '0;
                end else if (up_fire) begin
                    acc_d = acc_w;
                    k_d   = k_q + IDX_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q      <= '0;
                    k_q        <= '0;
                    out_q      <= '0;
                    out_last_q <= 1'b0;
                    out_val_q  <= 1'b0;
                end else begin
                    acc_q      <= acc_d;
                    k_q        <= k_d;
                    out_q      <= out_d;
                    out_last_q <= out_last_d;
                    out_val_q  <= out_val_d;
                end
            end
        end else begin : g_equal
            logic [DNW-1:0] out_q, out_d;
            logic           out_last_q, out_last_d;
            logic           out_val_q, out_val_d;
            logic           up_fire;

            assign up_rdy  = run_q & ~(out_val_q & ~dn_rdy);
            assign up_fire = up_val & up_rdy;
            assign dn_val  = out_val_q;
            assign dn_data = out_q;
            assign dn_last = out_last_q;

            always_comb begin
                out_d      = out_q;
                out_last_d = out_last_q;
                out_val_d  = out_val_q;
                if (up_fire) begin
                    out_d      = up_data;
                    out_last_d = up_last_eff;
                    out_val_d  = 1'b1;
                end else if (dn_rdy) begin
                    out_val_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q      <= '0;
                    out_last_q <= 1'b0;
                    out_val_q  <= 1'b0;
                end else begin
                    out_q      <= out_d;
                    out_last_q <= out_last_d;
                    out_val_q  <= out_val_d;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_str_gbox.sv
// Directed bench for str_gbox: a 24->8 downsizer and an 8->24 upsizer sharing one clock and reset.
module tb_str_gbox;
`ifdef STR_GBOX_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [23:0] d_up_data = '0;
    logic        d_up_last = 1'b0, d_up_val = 1'b0, d_up_rdy;
    logic [7:0]  d_dn_data;
    logic        d_dn_last, d_dn_val, d_dn_rdy = 1'b1;

    logic [7:0]  u_up_data = '0;
    logic        u_up_last = 1'b0, u_up_val = 1'b0, u_up_rdy;
    logic [23:0] u_dn_data;
    logic        u_dn_last, u_dn_val, u_dn_rdy = 1'b1;

    str_gbox #(.DATA_UP_WIDTH(24), .DATA_DN_WIDTH(8)) dut_down (
        .clk(clk), .rst(rst),
        .up_data(d_up_data), .up_last(d_up_last), .up_val(d_up_val), .up_rdy(d_up_rdy),
        .dn_data(d_dn_data), .dn_last(d_dn_last), .dn_val(d_dn_val), .dn_rdy(d_dn_rdy)
    );

    str_gbox #(.DATA_UP_WIDTH(8), .DATA_DN_WIDTH(24)) dut_up (
        .clk(clk), .rst(rst),
        .up_data(u_up_data), .up_last(u_up_last), .up_val(u_up_val), .up_rdy(u_up_rdy),
        .dn_data(u_dn_data), .dn_last(u_dn_last), .dn_val(u_dn_val), .dn_rdy(u_dn_rdy)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] nxt_s, exp_b;

    logic        ov, ol, orr;
    logic [7:0]  od;
    logic [23:0] ud;

    function automatic logic [23:0] mkw(input logic [7:0] s);
        return {s + 8'd2, s + 8'd1, s};
    endfunction

    // drive one cycle at negedge, sample just after, then let the posedge happen
    task automatic down_step(input logic rdy, input logic val, input logic [23:0] data, input logic last,
                             output logic o_val, output logic [7:0] o_data, output logic o_last,
                             output logic o_rdy);
        @(negedge clk);
        d_dn_rdy = rdy; d_up_val = val; d_up_data = data; d_up_last = last;
        #1;
        o_val = d_dn_val; o_data = d_dn_data; o_last = d_dn_last; o_rdy = d_up_rdy;
        $display("down: rdy=%0b val=%0b data=%06h | dn_val=%0b dn_data=%02h dn_last=%0b up_rdy=%0b",
                 rdy, val, data, o_val, o_data, o_last, o_rdy);
        @(posedge clk);
    endtask

    task automatic up_step(input logic rdy, input logic val, input logic [7:0] data, input logic last,
                           output logic o_val, output logic [23:0] o_data, output logic o_last,
                           output logic o_rdy);
        @(negedge clk);
        u_dn_rdy = rdy; u_up_val = val; u_up_data = data; u_up_last = last;
        #1;
        o_val = u_dn_val; o_data = u_dn_data; o_last = u_dn_last; o_rdy = u_up_rdy;
        $display("up: rdy=%0b val=%0b data=%02h last=%0b | dn_val=%0b dn_data=%06h dn_last=%0b up_rdy=%0b",
                 rdy, val, data, last, o_val, o_data, o_last, o_rdy);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; d_up_val = 1'b0; u_up_val = 1'b0; d_up_last = 1'b0; u_up_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
    endtask

    // down-side bookkeeping after a step: count consumed slices and accepted words
    task automatic down_book(input logic rdy, input logic val);
        if (ov && rdy) exp_b = exp_b + 8'd1;
        if (val && orr) nxt_s = nxt_s + 8'd3;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (d_dn_val !== 1'b0) begin failures++; $display("FAIL rst_d_val got=%0b want=0", d_dn_val); end
        checks++; if (d_dn_data !== 8'h00) begin failures++; $display("FAIL rst_d_data got=%02h want=00", d_dn_data); end
        checks++; if (d_dn_last !== 1'b0) begin failures++; $display("FAIL rst_d_last got=%0b want=0", d_dn_last); end
        checks++; if (d_up_rdy !== 1'b0) begin failures++; $display("FAIL rst_d_rdy got=%0b want=0", d_up_rdy); end
        checks++; if (u_dn_val !== 1'b0) begin failures++; $display("FAIL rst_u_val got=%0b want=0", u_dn_val); end
        checks++; if (u_dn_data !== 24'h0) begin failures++; $display("FAIL rst_u_data got=%06h want=000000", u_dn_data); end
        checks++; if (u_up_rdy !== 1'b0) begin failures++; $display("FAIL rst_u_rdy got=%0b want=0", u_up_rdy); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (d_up_rdy !== 1'b1) begin failures++; $display("FAIL rel_d_rdy got=%0b want=1", d_up_rdy); end
        checks++; if (u_up_rdy !== 1'b1) begin failures++; $display("FAIL rel_u_rdy got=%0b want=1", u_up_rdy); end
        checks++; if (d_dn_val !== 1'b0) begin failures++; $display("FAIL rel_d_val got=%0b want=0", d_dn_val); end
    endtask

    task automatic test_down_continuous();
        logic exp_rdy;
        nxt_s = 8'd1; exp_b = 8'd1;
        for (int c = 0; c < 12; c++) begin
            down_step(1'b1, 1'b1, mkw(nxt_s), 1'b0, ov, od, ol, orr);
            exp_rdy = !ov || (exp_b % 3 == 0);
            checks++; if (orr !== exp_rdy) begin failures++; $display("FAIL cont_rdy c=%0d got=%0b want=%0b", c, orr, exp_rdy); end
            checks++; if (ov !== (c > 0)) begin failures++; $display("FAIL cont_val c=%0d got=%0b want=%0b", c, ov, (c > 0)); end
            if (ov) begin
                checks++; if (od !== exp_b) begin failures++; $display("FAIL cont_data c=%0d got=%02h want=%02h", c, od, exp_b); end
            end
            down_book(1'b1, 1'b1);
        end
        checks++; if (exp_b !== 8'd12) begin failures++; $display("FAIL cont_count got=%0d want=12", exp_b); end
    endtask

    task automatic align_mid_word(input string tag);
        for (int c = 0; c < 3 && (exp_b % 3) != 2; c++) begin
            down_step(1'b1, 1'b1, mkw(nxt_s), 1'b0, ov, od, ol, orr);
            checks++; if (ov !== 1'b1 || od !== exp_b) begin failures++; $display("FAIL %s_align got=%0b/%02h want=1/%02h", tag, ov, od, exp_b); end
            down_book(1'b1, 1'b1);
        end
        checks++; if ((exp_b % 3) != 2) begin failures++; $display("FAIL %s_align_idx got=%0d want=2", tag, exp_b % 3); end
    endtask

    task automatic test_down_backpressure();
        align_mid_word("bp");
        for (int c = 0; c < 10; c++) begin
            down_step(1'b0, 1'b1, mkw(nxt_s), 1'b0, ov, od, ol, orr);
            checks++; if (ov !== 1'b1 || od !== exp_b) begin failures++; $display("FAIL bp_hold c=%0d got=%0b/%02h want=1/%02h", c, ov, od, exp_b); end
            checks++; if (orr !== 1'b0) begin failures++; $display("FAIL bp_rdy c=%0d got=%0b want=0", c, orr); end
            down_book(1'b0, 1'b1);
        end
        for (int c = 0; c < 9; c++) begin
            down_step(1'b1, 1'b1, mkw(nxt_s), 1'b0, ov, od, ol, orr);
            checks++; if (ov !== 1'b1 || od !== exp_b) begin failures++; $display("FAIL bp_resume c=%0d got=%0b/%02h want=1/%02h", c, ov, od, exp_b); end
            down_book(1'b1, 1'b1);
        end
    endtask

    task automatic test_reset_midstream();
        align_mid_word("rm");
        @(negedge clk);
        rst = 1'b1; d_up_val = 1'b1; d_dn_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (d_dn_val !== 1'b0) begin failures++; $display("FAIL rm_val got=%0b want=0", d_dn_val); end
        checks++; if (d_up_rdy !== 1'b0) begin failures++; $display("FAIL rm_rdy got=%0b want=0", d_up_rdy); end
        rst = 1'b0; d_up_val = 1'b0;
        @(posedge clk);
        nxt_s = 8'h41; exp_b = 8'h41;
        down_step(1'b1, 1'b1, mkw(nxt_s), 1'b0, ov, od, ol, orr);
        checks++; if (orr !== 1'b1 || ov !== 1'b0) begin failures++; $display("FAIL rm_restart got=rdy%0b/val%0b want=rdy1/val0", orr, ov); end
        down_step(1'b1, 1'b0, 24'h0, 1'b0, ov, od, ol, orr);
        checks++; if (ov !== 1'b1 || od !== 8'h41) begin failures++; $display("FAIL rm_first got=%0b/%02h want=1/41", ov, od); end
    endtask

    task automatic test_down_last();
        logic [23:0] w;
        logic exp_l;
        w = 24'h0C0B0A;
        do_reset();
        down_step(1'b1, 1'b1, w, 1'b1, ov, od, ol, orr);
        checks++; if (orr !== 1'b1) begin failures++; $display("FAIL last_accept got=%0b want=1", orr); end
        for (int i = 0; i < 3; i++) begin
            down_step(1'b1, 1'b0, 24'h0, 1'b0, ov, od, ol, orr);
            exp_l = LAST_EN && (i == 2);
            checks++; if (ov !== 1'b1 || od !== w[i*8 +: 8]) begin failures++; $display("FAIL last_data i=%0d got=%0b/%02h want=1/%02h", i, ov, od, w[i*8 +: 8]); end
            checks++; if (ol !== exp_l) begin failures++; $display("FAIL last_flag i=%0d got=%0b want=%0b", i, ol, exp_l); end
        end
        down_step(1'b1, 1'b0, 24'h0, 1'b0, ov, od, ol, orr);
        checks++; if (ov !== 1'b0 || ol !== 1'b0) begin failures++; $display("FAIL last_empty got=%0b/%0b want=0/0", ov, ol); end
    endtask

    task automatic test_toggle_ready();
        logic rdy;
        do_reset();
        nxt_s = 8'd1; exp_b = 8'd1;
        for (int c = 0; c < 24; c++) begin
            rdy = (c % 2 == 0);
            down_step(rdy, 1'b1, mkw(nxt_s), 1'b0, ov, od, ol, orr);
            checks++; if (ov !== (c > 0)) begin failures++; $display("FAIL tog_val c=%0d got=%0b want=%0b", c, ov, (c > 0)); end
            if (ov && rdy) begin
                checks++; if (od !== exp_b) begin failures++; $display("FAIL tog_data c=%0d got=%02h want=%02h", c, od, exp_b); end
            end
            down_book(rdy, 1'b1);
        end
        checks++; if (exp_b !== 8'd12) begin failures++; $display("FAIL tog_count got=%0d want=12", exp_b); end
    endtask

    task automatic test_up_pack();
        do_reset();
        up_step(1'b1, 1'b1, 8'h01, 1'b0, ov, ud, ol, orr);
        checks++; if (orr !== 1'b1 || ov !== 1'b0) begin failures++; $display("FAIL up_s1 got=rdy%0b/val%0b want=rdy1/val0", orr, ov); end
        up_step(1'b1, 1'b1, 8'h02, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL up_s2 got=%0b want=0", ov); end
        up_step(1'b1, 1'b1, 8'h03, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== 1'b0 || orr !== 1'b1) begin failures++; $display("FAIL up_s3 got=val%0b/rdy%0b want=val0/rdy1", ov, orr); end
        up_step(1'b1, 1'b0, 8'h00, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== 1'b1 || ud !== 24'h030201 || ol !== 1'b0) begin failures++; $display("FAIL up_word got=%0b/%06h/%0b want=1/030201/0", ov, ud, ol); end
        up_step(1'b1, 1'b0, 8'h00, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL up_drain got=%0b want=0", ov); end
        up_step(1'b0, 1'b1, 8'h04, 1'b0, ov, ud, ol, orr);
        up_step(1'b0, 1'b1, 8'h05, 1'b0, ov, ud, ol, orr);
        up_step(1'b0, 1'b1, 8'h06, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== 1'b0 || orr !== 1'b1) begin failures++; $display("FAIL up_bp_fill got=val%0b/rdy%0b want=val0/rdy1", ov, orr); end
        for (int c = 0; c < 2; c++) begin
            up_step(1'b0, 1'b1, 8'h07, 1'b0, ov, ud, ol, orr);
            checks++; if (ov !== 1'b1 || ud !== 24'h060504 || orr !== 1'b0) begin failures++; $display("FAIL up_bp_hold c=%0d got=%0b/%06h/rdy%0b want=1/060504/rdy0", c, ov, ud, orr); end
        end
        up_step(1'b1, 1'b1, 8'h07, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== 1'b1 || orr !== 1'b1) begin failures++; $display("FAIL up_bp_release got=val%0b/rdy%0b want=val1/rdy1", ov, orr); end
        up_step(1'b1, 1'b0, 8'h00, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL up_bp_partial got=%0b want=0", ov); end
    endtask

    task automatic test_up_last();
        do_reset();
        up_step(1'b1, 1'b1, 8'h01, 1'b0, ov, ud, ol, orr);
        up_step(1'b1, 1'b1, 8'h02, 1'b1, ov, ud, ol, orr);
        up_step(1'b1, 1'b0, 8'h00, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== LAST_EN) begin failures++; $display("FAIL uplast_val got=%0b want=%0b", ov, LAST_EN); end
        if (ov) begin
            checks++; if (ud !== 24'h000201 || ol !== 1'b1) begin failures++; $display("FAIL uplast_word got=%06h/%0b want=000201/1", ud, ol); end
        end
        up_step(1'b1, 1'b1, 8'h03, 1'b0, ov, ud, ol, orr);
        up_step(1'b1, 1'b0, 8'h00, 1'b0, ov, ud, ol, orr);
        checks++; if (ov !== !LAST_EN) begin failures++; $display("FAIL uplast_after got=%0b want=%0b", ov, !LAST_EN); end
        if (ov) begin
            checks++; if (ud !== 24'h030201 || ol !== 1'b0) begin failures++; $display("FAIL uplast_full got=%06h/%0b want=030201/0", ud, ol); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_down_continuous();
        test_down_backpressure();
        test_reset_midstream();
        test_down_last();
        test_toggle_ready();
        test_up_pack();
        test_up_last();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
